// File: rtl/multi_integer_to_fixed_stream_pkg.sv
// Purpose: shared state encoding and geometry helpers for the integer-to-fixed streamer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package multi_integer_to_fixed_stream_pkg;

    // Two-state controller: no block held, or a block held with beats still to emit.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    // Width of one fixed-point output word.
    function automatic int calc_w(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    // Number of output beats needed to drain one input block.
    function automatic int calc_beats(input int num_integers, input int lanes);
        return num_integers / lanes;
    endfunction

    // Beat counter width; never zero so a single-beat block still has a legal counter.
    function automatic int calc_bw(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/integer_to_fixed_lane.sv
// Purpose: convert one unsigned sample to a signed fixed-point word, optionally re-centred around zero.
// Latency: purely combinational.
// Backpressure: none; the caller holds the sample stable.
module integer_to_fixed_lane
    import multi_integer_to_fixed_stream_pkg::*;
#(
    parameter int INT_BITS   = 16,
    parameter int FRAC_BITS  = 16,
    parameter int INPUT_BITS = 8,
    localparam int W         = calc_w(INT_BITS, FRAC_BITS)
) (
    input  logic [INPUT_BITS-1:0] sample_i,
    input  logic                  level_shift_i,
    output logic [W-1:0]          fixed_o
);

    logic [INPUT_BITS:0] offset;
    logic [INPUT_BITS:0] centred;
    logic [W-1:0]        widened;

    // One extra bit holds the sign of the re-centred value; with no shift the
    // top bit is zero, so the same sign extension doubles as zero extension.
    always_comb begin
        offset                   = '0;
        offset[INPUT_BITS-1]     = level_shift_i;
        centred                  = {1'b0, sample_i} - offset;
        widened                  = W'($signed(centred));
        fixed_o                  = widened << FRAC_BITS;
    end

endmodule

// File: rtl/multi_integer_to_fixed_stream.sv
// Purpose: accept a block of unsigned samples and stream it out LANES fixed-point words per beat.
// Latency: beat 0 appears the cycle after the input handshake; conversion adds no cycles.
// Backpressure: out_ready low freezes the current beat; a new block is only taken while idle or on the final beat's handshake.
module multi_integer_to_fixed_stream
    import multi_integer_to_fixed_stream_pkg::*;
#(
    parameter int INT_BITS     = 16,
    parameter int FRAC_BITS    = 16,
    parameter int INPUT_BITS   = 8,
    parameter int NUM_INTEGERS = 64,
    parameter int LANES        = 8,
    localparam int W           = calc_w(INT_BITS, FRAC_BITS),
    localparam int BEATS       = calc_beats(NUM_INTEGERS, LANES),
    localparam int BW          = calc_bw(BEATS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               level_shift,
    input  logic [NUM_INTEGERS*INPUT_BITS-1:0] integers,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LANES*W-1:0]                 out_data,
    output logic [BW-1:0]                      out_beat,
    output logic                               out_last
);

    generate
        if ((NUM_INTEGERS % LANES) != 0 || INT_BITS < INPUT_BITS + 1) begin : g_bad_cfg
            $error("multi_integer_to_fixed_stream: NUM_INTEGERS must be a multiple of LANES and INT_BITS >= INPUT_BITS+1");
        end
    endgenerate

    localparam int            BEAT_SAMPLE_BITS = LANES * INPUT_BITS;
    localparam logic [BW-1:0] LAST_BEAT        = BW'(BEATS - 1);

    logic [0:0]                                  state_q, state_d;
    logic [BW-1:0]                               beat_q, beat_d;
    logic                                        shift_q, shift_d;
    logic [BEATS-1:0][BEAT_SAMPLE_BITS-1:0]      samples_q, samples_d;

    logic                        last_beat;
    logic                        out_fire;
    logic                        accept;
    logic [BEAT_SAMPLE_BITS-1:0] beat_samples;
    logic [LANES*W-1:0]          lane_data;

    assign out_valid = (state_q == ST_EMIT);
    assign last_beat = (beat_q == LAST_BEAT);
    assign out_fire  = out_valid && out_ready;
    // Ready while empty, or exactly when the final beat leaves, so blocks chain without a bubble.
    assign in_ready  = !rst && ((state_q == ST_IDLE) || (out_fire && last_beat));
    assign accept    = in_valid && in_ready;

    assign out_beat  = beat_q;
    assign out_last  = out_valid && last_beat;

    assign beat_samples = samples_q[beat_q];

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            integer_to_fixed_lane #(
                .INT_BITS   (INT_BITS),
                .FRAC_BITS  (FRAC_BITS),
                .INPUT_BITS (INPUT_BITS)
            ) u_lane (
                .sample_i      (beat_samples[k*INPUT_BITS +: INPUT_BITS]),
                .level_shift_i (shift_q),
                .fixed_o       (lane_data[k*W +: W])
            );
        end
    endgenerate

    // Sample registers are not reset, so the output is masked to zero whenever no beat is offered.
    assign out_data = out_valid ? lane_data : '0;

    // Next-state: a new block always wins over advancing, since it can only arrive on the last beat.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        shift_d   = shift_q;
        samples_d = samples_q;
        if (accept) begin
            state_d   = ST_EMIT;
            beat_d    = '0;
            shift_d   = level_shift;
            samples_d = integers;
        end else if (out_fire) begin
            if (last_beat) begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end else begin
                beat_d  = beat_q + 1'b1;
            end
        end
    end

    // Control state: reset drops any held or half-sent block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            shift_q <= shift_d;
        end
    end

    // Held block data: only meaningful while emitting, so it carries no reset.
    always_ff @(posedge clk) begin
        samples_q <= samples_d;
    end

endmodule

// File: tb/tb_multi_integer_to_fixed_stream.sv
module tb_multi_integer_to_fixed_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         level_shift;
    logic [511:0] integers;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [2:0]   out_beat;
    logic         out_last;

    int vectors     = 0;
    int miscompares = 0;

    multi_integer_to_fixed_stream dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .level_shift (level_shift),
        .integers    (integers),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_beat    (out_beat),
        .out_last    (out_last)
    );

    initial forever #5 clk = ~clk;

    // Reference conversion of all eight lanes of one beat.
    function automatic logic [255:0] exp_beat(input logic [511:0] blk, input logic ls, input int b);
        logic [255:0] r;
        logic [7:0]   s;
        logic [31:0]  v;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            s = blk[(b*8+k)*8 +: 8];
            v = ls ? (32'(s) - 32'd128) : 32'(s);
            r[k*32 +: 32] = v << 16;
        end
        return r;
    endfunction

    function automatic logic [511:0] mk_block(input int mul, input int add);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'((i * mul + add) & 255);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; level_shift = 1'b0; out_ready = 1'b1;
        integers = mk_block(1, 7);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({out_valid, out_beat, out_last} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got v=%b beat=%0d last=%b want 0/0/0", out_valid, out_beat, out_last);
        end
        vectors++;
        if (out_data !== 256'h0) begin
            miscompares++; $display("FAIL reset_data got %h want 0", out_data);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        rst = 1'b0; in_valid = 1'b0; #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL post_reset got rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_ramp();
        logic [511:0] blk;
        blk = mk_block(1, 0);
        @(negedge clk);
        in_valid = 1'b1; integers = blk; level_shift = 1'b0; out_ready = 1'b1; #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL ramp_accept got rdy=%b want 1", in_ready);
        end
        for (int b = 0; b < 8; b++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            vectors++;
            if ({out_valid, out_beat, out_last} !== {1'b1, 3'(b), b == 7}) begin
                miscompares++;
                $display("FAIL ramp_ctrl b=%0d got v=%b beat=%0d last=%b", b, out_valid, out_beat, out_last);
            end
            vectors++;
            if (out_data !== exp_beat(blk, 1'b0, b)) begin
                miscompares++; $display("FAIL ramp_data b=%0d got %h want %h", b, out_data, exp_beat(blk, 1'b0, b));
            end
            if (b == 0) begin
                vectors++;
                if (out_data[63:32] !== 32'h0001_0000) begin
                    miscompares++; $display("FAIL ramp_b0_l1 got %h want 00010000", out_data[63:32]);
                end
            end
            if (b == 7) begin
                vectors++;
                if (out_data[255:224] !== 32'h003F_0000) begin
                    miscompares++; $display("FAIL ramp_b7_l7 got %h want 003f0000", out_data[255:224]);
                end
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            miscompares++; $display("FAIL ramp_idle got v=%b last=%b want 0/0", out_valid, out_last);
        end
    endtask

    task automatic test_level_shift();
        logic [511:0] blk;
        blk = mk_block(4, 0);
        blk[7:0]  = 8'd0;
        blk[15:8] = 8'd255;
        @(negedge clk);
        in_valid = 1'b1; integers = blk; level_shift = 1'b1; out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk); in_valid = 1'b0; level_shift = 1'b0; #1;
            vectors++;
            if ({out_valid, out_beat, out_last} !== {1'b1, 3'(b), b == 7}) begin
                miscompares++;
                $display("FAIL shift_ctrl b=%0d got v=%b beat=%0d last=%b", b, out_valid, out_beat, out_last);
            end
            vectors++;
            if (out_data !== exp_beat(blk, 1'b1, b)) begin
                miscompares++; $display("FAIL shift_data b=%0d got %h want %h", b, out_data, exp_beat(blk, 1'b1, b));
            end
            if (b == 0) begin
                vectors++;
                if (out_data[63:0] !== 64'h007F_0000_FF80_0000) begin
                    miscompares++; $display("FAIL shift_extremes got %h want 007f0000ff800000", out_data[63:0]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [511:0] blk;
        int           eb;
        blk = mk_block(255, 255);
        @(negedge clk);
        in_valid = 1'b1; integers = blk; level_shift = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = (c < 3) || (c >= 8);
            eb = (c < 3) ? c : ((c <= 8) ? 3 : c - 5);
            #1;
            vectors++;
            if ({out_valid, out_beat, out_last} !== {1'b1, 3'(eb), eb == 7}) begin
                miscompares++;
                $display("FAIL stall_ctrl c=%0d got v=%b beat=%0d want beat %0d", c, out_valid, out_beat, eb);
            end
            vectors++;
            if (out_data !== exp_beat(blk, 1'b0, eb)) begin
                miscompares++; $display("FAIL stall_data c=%0d got %h want %h", c, out_data, exp_beat(blk, 1'b0, eb));
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL stall_idle got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] blk_a;
        logic [511:0] blk_b;
        blk_a = mk_block(1, 100);
        blk_b = mk_block(3, 1);
        @(negedge clk);
        in_valid = 1'b1; integers = blk_a; level_shift = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); integers = blk_b; level_shift = 1'b1; #1;
            vectors++;
            if ({out_valid, out_beat, in_ready} !== {1'b1, 3'(c), c == 7}) begin
                miscompares++;
                $display("FAIL b2b_a_ctrl c=%0d got v=%b beat=%0d rdy=%b", c, out_valid, out_beat, in_ready);
            end
            vectors++;
            if (out_data !== exp_beat(blk_a, 1'b0, c)) begin
                miscompares++; $display("FAIL b2b_a_data c=%0d got %h want %h", c, out_data, exp_beat(blk_a, 1'b0, c));
            end
        end
        for (int b = 0; b < 8; b++) begin
            @(negedge clk); in_valid = 1'b0; level_shift = 1'b0; #1;
            vectors++;
            if ({out_valid, out_beat, out_last} !== {1'b1, 3'(b), b == 7}) begin
                miscompares++;
                $display("FAIL b2b_b_ctrl b=%0d got v=%b beat=%0d last=%b", b, out_valid, out_beat, out_last);
            end
            vectors++;
            if (out_data !== exp_beat(blk_b, 1'b1, b)) begin
                miscompares++; $display("FAIL b2b_b_data b=%0d got %h want %h", b, out_data, exp_beat(blk_b, 1'b1, b));
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] blk_a;
        logic [511:0] blk_c;
        blk_a = mk_block(5, 3);
        blk_c = mk_block(7, 9);
        @(negedge clk);
        in_valid = 1'b1; integers = blk_a; level_shift = 1'b0; out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            vectors++;
            if (out_beat !== 3'(b) || out_data !== exp_beat(blk_a, 1'b0, b)) begin
                miscompares++; $display("FAIL rmid_pre b=%0d got beat=%0d data=%h", b, out_beat, out_data);
            end
        end
        rst = 1'b1; #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL rmid_rdy got %b want 0", in_ready);
        end
        @(negedge clk); rst = 1'b0; #1;
        vectors++;
        if ({out_valid, out_beat, out_last} !== 5'b0 || out_data !== 256'h0) begin
            miscompares++;
            $display("FAIL rmid_cleared got v=%b beat=%0d last=%b data=%h", out_valid, out_beat, out_last, out_data);
        end
        in_valid = 1'b1; integers = blk_c; level_shift = 1'b1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk); in_valid = 1'b0; level_shift = 1'b0; #1;
            vectors++;
            if ({out_valid, out_beat, out_last} !== {1'b1, 3'(b), b == 7}) begin
                miscompares++;
                $display("FAIL rmid_ctrl b=%0d got v=%b beat=%0d last=%b", b, out_valid, out_beat, out_last);
            end
            vectors++;
            if (out_data !== exp_beat(blk_c, 1'b1, b)) begin
                miscompares++; $display("FAIL rmid_data b=%0d got %h want %h", b, out_data, exp_beat(blk_c, 1'b1, b));
            end
        end
    endtask

    task automatic test_ignore_mid();
        logic [511:0] blk_a;
        logic [511:0] blk_b;
        blk_a = mk_block(9, 17);
        blk_b = mk_block(11, 200);
        @(negedge clk);
        in_valid = 1'b1; integers = blk_a; level_shift = 1'b0; out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            in_valid    = (b == 2);
            integers    = (b == 2) ? blk_b : blk_a;
            level_shift = (b == 2);
            #1;
            if (b == 2) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++; $display("FAIL ignore_rdy got %b want 0", in_ready);
                end
            end
            vectors++;
            if ({out_valid, out_beat, out_last} !== {1'b1, 3'(b), b == 7}) begin
                miscompares++;
                $display("FAIL ignore_ctrl b=%0d got v=%b beat=%0d last=%b", b, out_valid, out_beat, out_last);
            end
            vectors++;
            if (out_data !== exp_beat(blk_a, 1'b0, b)) begin
                miscompares++; $display("FAIL ignore_data b=%0d got %h want %h", b, out_data, exp_beat(blk_a, 1'b0, b));
            end
        end
        @(negedge clk); in_valid = 1'b0; #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL ignore_idle got v=%b want 0", out_valid);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; level_shift = 1'b0; out_ready = 1'b0; integers = '0;
        test_reset();
        test_ramp();
        test_level_shift();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_ignore_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
